// File: rtl/j1_io_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : j1_io_ctrl
// Description : Wait-state I/O controller. It turns each j1 single-cycle I/O
//               strobe into one handshaked bus transaction. The core is held
//               on `pause` until the peripheral acks or a timeout expires.
//               It also merges an external debug halt into `pause`.
// Revision    : 1.0 - initial release
// ============================================================================
module j1_io_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic        sys_clk_i,
  input  logic        sys_rst_i,
  input  logic        halt_i,
  output logic        cpu_pause_o,
  input  logic        cpu_io_rd_i,
  input  logic        cpu_io_wr_i,
  input  logic [15:0] cpu_io_addr_i,
  input  logic [15:0] cpu_io_dout_i,
  output logic [15:0] cpu_io_din_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [15:0] bus_addr_o,
  output logic [15:0] bus_wdata_o,
  input  logic [15:0] bus_rdata_i,
  input  logic        bus_ack_i,
  output logic        bus_err_o,
  input  logic        err_clr_i
);

  localparam logic [15:0] C_TIMEOUT = 16'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [15:0] rdata_q, rdata_d;
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;

  logic        strobe;
  logic        timeout;
  logic        pause_fsm;

  assign strobe = cpu_io_rd_i | cpu_io_wr_i;

  // Next-state, latch, counter and error-flag decode.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    rdata_d   = rdata_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    timeout   = 1'b0;
    pause_fsm = 1'b0;

    case (state_q)
      S_IDLE: begin
        pause_fsm = halt_i | strobe;
        // A strobe seen while halted is left pending; the core re-presents it.
        if (strobe && !halt_i) begin
          addr_d  = cpu_io_addr_i;
          wdata_d = cpu_io_dout_i;
          we_d    = cpu_io_wr_i;   // rd & wr together counts as a write
          cnt_d   = 16'd0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        pause_fsm = 1'b1;
        // An ack in the last allowed cycle takes priority over the timeout.
        if (bus_ack_i) begin
          rdata_d = bus_rdata_i;
          state_d = S_DONE;
        end else if (cnt_q >= C_TIMEOUT) begin
          rdata_d = 16'hFFFF;
          timeout = 1'b1;
          state_d = S_DONE;
        end else if (cnt_q != 16'hFFFF) begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_DONE: begin
        // The strobe here belongs to the committing instruction; never relaunch.
        pause_fsm = halt_i;
        if (!halt_i) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A timeout in the same cycle as a clear leaves the flag set.
    if (err_clr_i) begin
      err_d = 1'b0;
    end
    if (timeout) begin
      err_d = 1'b1;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      state_q <= S_IDLE;
      addr_q  <= 16'd0;
      wdata_q <= 16'd0;
      we_q    <= 1'b0;
      rdata_q <= 16'd0;
      cnt_q   <= 16'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // While reset is asserted the pause output follows the IDLE decode.
  assign cpu_pause_o  = sys_rst_i ? (halt_i | strobe) : pause_fsm;
  assign bus_req_o    = (state_q == S_REQ);
  assign bus_we_o     = we_q;
  assign bus_addr_o   = addr_q;
  assign bus_wdata_o  = wdata_q;
  assign cpu_io_din_o = rdata_q;
  assign bus_err_o    = err_q;

endmodule
`default_nettype wire
